// File: rtl/execute_if.sv
// rtl/execute_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage

interface execute_if;
    logic        id_valid;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic [5:0]  ctr_m_in;
    logic [1:0]  ctr_wb_in;
    logic [31:0] reg1_data;
    logic [31:0] reg2_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [31:0] fwd_mem_data;
    logic [31:0] fwd_wb_data;
    logic        flush;

    logic [31:0] ex_ALU_out;
    logic [31:0] ex_reg2_data;
    logic [4:0]  ex_write_reg;
    logic [5:0]  ex_ctr_m;
    logic [1:0]  ex_ctr_wb;
    logic        ex_zero;
    logic        stall;

    // Driver side: the decode stage / pipeline around the execute stage.
    modport master (
        output id_valid, alu_op, alu_src, reg_dst, ctr_m_in, ctr_wb_in,
               reg1_data, reg2_data, imm, shamt, rt, rd,
               forward_a, forward_b, fwd_mem_data, fwd_wb_data, flush,
        input  ex_ALU_out, ex_reg2_data, ex_write_reg, ex_ctr_m, ex_ctr_wb,
               ex_zero, stall
    );

    // The execute stage itself.
    modport slave (
        input  id_valid, alu_op, alu_src, reg_dst, ctr_m_in, ctr_wb_in,
               reg1_data, reg2_data, imm, shamt, rt, rd,
               forward_a, forward_b, fwd_mem_data, fwd_wb_data, flush,
        output ex_ALU_out, ex_reg2_data, ex_write_reg, ex_ctr_m, ex_ctr_wb,
               ex_zero, stall
    );
endinterface

// File: rtl/execute.sv
// rtl/execute.sv - pipeline execute stage: forwarding, ALU, EX/MEM register, optional multi-cycle MUL (EXECUTE_MUL_EN)

module execute (
    input  logic      clk,
    input  logic      rst,
    execute_if.slave  bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_LUI = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1111;

    logic [31:0] op_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [4:0]  write_reg;
    logic        load_alu;
    logic        load_mul;
    logic        stall_int;
    logic        mul_req;

    assign mul_req   = bus.id_valid && (bus.alu_op == OP_MUL);
    assign write_reg = bus.reg_dst ? bus.rd : bus.rt;
    assign bus.stall = stall_int;

    // Forwarding muxes for both operands; 11 falls back to the register file.
    always_comb begin
        case (bus.forward_a)
            2'b10:   op_a = bus.fwd_mem_data;
            2'b01:   op_a = bus.fwd_wb_data;
            default: op_a = bus.reg1_data;
        endcase
        case (bus.forward_b)
            2'b10:   fwd_b = bus.fwd_mem_data;
            2'b01:   fwd_b = bus.fwd_wb_data;
            default: fwd_b = bus.reg2_data;
        endcase
        op_b = bus.alu_src ? bus.imm : fwd_b;
    end

    // Single-cycle ALU; MUL and unused encodings produce 0 here.
    always_comb begin
        case (bus.alu_op)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLT:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLL:  alu_res = op_b << bus.shamt;
            OP_SRL:  alu_res = op_b >> bus.shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> bus.shamt);
            OP_LUI:  alu_res = {bus.imm[15:0], 16'd0};
            default: alu_res = 32'd0;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] acc;
    logic [5:0]  count;
    logic [31:0] hold_b;
    logic [4:0]  hold_wr;
    logic [5:0]  hold_m;
    logic [1:0]  hold_wb;

    // MUL state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // MUL next-state: accept, 32 shift-add steps, one result edge; flush aborts.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mul_req && !bus.flush) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (count == 6'd31) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // MUL outputs: stall upstream and choose what the EX/MEM register loads.
    always_comb begin
        stall_int = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        case (state)
            IDLE: begin
                stall_int = mul_req && !bus.flush;
                load_alu  = bus.id_valid && !bus.flush && (bus.alu_op != OP_MUL);
            end
            BUSY: begin
                stall_int = 1'b1;
            end
            DONE: begin
                // The ID/EX register still holds the MUL itself this cycle.
                load_mul = !bus.flush;
            end
            default: begin
                stall_int = 1'b0;
            end
        endcase
    end

    // Multiplier datapath: operands and controls frozen at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a   <= 32'd0;
            mul_b   <= 32'd0;
            acc     <= 32'd0;
            count   <= 6'd0;
            hold_b  <= 32'd0;
            hold_wr <= 5'd0;
            hold_m  <= 6'd0;
            hold_wb <= 2'd0;
        end else if (state == IDLE && state_nx == BUSY) begin
            mul_a   <= op_a;
            mul_b   <= op_b;
            acc     <= 32'd0;
            count   <= 6'd0;
            hold_b  <= fwd_b;
            hold_wr <= write_reg;
            hold_m  <= bus.ctr_m_in;
            hold_wb <= bus.ctr_wb_in;
        end else if (state == BUSY && !bus.flush) begin
            if (mul_b[0]) begin
                acc <= acc + mul_a;
            end
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            count <= count + 6'd1;
        end
    end
`else
    // Without the multiplier there is never a stall and MUL becomes a bubble.
    always_comb begin
        stall_int = 1'b0;
        load_mul  = 1'b0;
        load_alu  = bus.id_valid && !bus.flush && (bus.alu_op != OP_MUL);
    end
`endif

    // EX/MEM register: ALU result, MUL result, or an all-zero bubble.
    // A bubble also clears ex_zero so it looks exactly like the reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_ALU_out   <= 32'd0;
            bus.ex_reg2_data <= 32'd0;
            bus.ex_write_reg <= 5'd0;
            bus.ex_ctr_m     <= 6'd0;
            bus.ex_ctr_wb    <= 2'd0;
            bus.ex_zero      <= 1'b0;
        end else if (load_alu) begin
            bus.ex_ALU_out   <= alu_res;
            bus.ex_reg2_data <= fwd_b;
            bus.ex_write_reg <= write_reg;
            bus.ex_ctr_m     <= bus.ctr_m_in;
            bus.ex_ctr_wb    <= bus.ctr_wb_in;
            bus.ex_zero      <= (alu_res == 32'd0);
`ifdef EXECUTE_MUL_EN
        end else if (load_mul) begin
            bus.ex_ALU_out   <= acc;
            bus.ex_reg2_data <= hold_b;
            bus.ex_write_reg <= hold_wr;
            bus.ex_ctr_m     <= hold_m;
            bus.ex_ctr_wb    <= hold_wb;
            bus.ex_zero      <= (acc == 32'd0);
`endif
        end else begin
            bus.ex_ALU_out   <= 32'd0;
            bus.ex_reg2_data <= 32'd0;
            bus.ex_write_reg <= 5'd0;
            bus.ex_ctr_m     <= 6'd0;
            bus.ex_ctr_wb    <= 2'd0;
            bus.ex_zero      <= 1'b0;
        end
    end

`ifndef EXECUTE_MUL_EN
    logic unused_ok;
    assign unused_ok = load_mul;
`endif

endmodule
